// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_pkg
//  Brief    : Shared command codes, address length and state encoding for
//             the SPI flash responder.
//  Revision : 1.0  initial release
// ============================================================================
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WAKE   = 8'hAB;
  localparam int         ADDR_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_in_sync
//  Brief    : Two-flop synchronisers for CS, SCLK and MOSI plus SCLK
//             rise/fall detection on the synchronised clock.
//  Revision : 1.0  initial release
// ============================================================================
module spi_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs_i,
  input  logic spi_sclk_i,
  input  logic spi_mosi_i,
  output logic cs_o,
  output logic mosi_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);

  // Bit order inside the vectors: [2]=CS, [1]=SCLK, [0]=MOSI.
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       sclk_prev_q;

  // Synchroniser chain; everything idles high so reset looks like "deselected".
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= 3'b111;
      sync_q      <= 3'b111;
      sclk_prev_q <= 1'b1;
    end else begin
      meta_q      <= {spi_cs_i, spi_sclk_i, spi_mosi_i};
      sync_q      <= meta_q;
      sclk_prev_q <= sync_q[1];
    end
  end

  assign cs_o        = sync_q[2];
  assign mosi_o      = sync_q[0];
  assign sclk_rise_o =  sync_q[1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sync_q[1] &  sclk_prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_responder
//  Brief    : Mode-3 SPI flash responder supporting wake (0xAB) and read
//             (0x03 + 24-bit address) with a one-byte prefetching fetch path.
//  Revision : 1.0  initial release
// ============================================================================
module spi_flash_responder #(
  parameter bit START_AWAKE = 1'b0,
  parameter int MEM_AW      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              awake,
  output logic              underrun
);
  import spi_flash_pkg::*;

  localparam logic [MEM_AW-1:0] c_addr_one  = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [1:0]        c_last_addr = 2'(ADDR_BYTES - 1);

  logic cs_s, mosi_s, rise, fall;

  spi_in_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_i   (spi_cs),
    .spi_sclk_i (spi_sclk),
    .spi_mosi_i (spi_mosi),
    .cs_o       (cs_s),
    .mosi_o     (mosi_s),
    .sclk_rise_o(rise),
    .sclk_fall_o(fall)
  );

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        shin_q, shin_d;        // previous 7 MOSI bits of the byte
  logic [MEM_AW-2:0] addr_sh_q, addr_sh_d;  // address bits received so far
  logic [1:0]        addr_cnt_q, addr_cnt_d;
  logic [MEM_AW-1:0] next_addr_q, next_addr_d; // address of next byte to load
  logic              want_q, want_d;        // fetch requested but not issued
  logic              mem_valid_q, mem_valid_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              discard_q, discard_d;  // outstanding fetch is stale
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [7:0]        shout_q, shout_d;
  logic              miso_q, miso_d;
  logic              awake_q, awake_d;
  logic              underrun_q, underrun_d;

  logic [7:0]        w_byte;
  logic              w_byte_done;
  logic              w_addr_done;
  logic              w_load;
  logic              w_want;
  logic [MEM_AW-1:0] w_want_addr;

  // Next-state logic: command decode, bit shifting, holding register and fetch issue.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shin_d      = shin_q;
    addr_sh_d   = addr_sh_q;
    addr_cnt_d  = addr_cnt_q;
    next_addr_d = next_addr_q;
    want_d      = want_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    discard_d   = discard_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shout_d     = shout_q;
    miso_d      = miso_q;
    awake_d     = awake_q;
    underrun_d  = underrun_q;
    w_byte      = {shin_q, mosi_s};
    w_byte_done = rise && (bitcnt_q == 3'd7);
    w_addr_done = 1'b0;
    w_load      = 1'b0;
    w_want      = 1'b0;
    w_want_addr = next_addr_q;

    if (cs_s) begin
      // Deselect aborts the transaction; an in-flight fetch becomes stale.
      state_d     = IDLE;
      bitcnt_d    = 3'd0;
      miso_d      = 1'b1;
      want_d      = 1'b0;
      hold_full_d = 1'b0;
      if (mem_valid_q) discard_d = 1'b1;
    end else begin
      if (rise) begin
        bitcnt_d = bitcnt_q + 3'd1;
        shin_d   = w_byte[6:0];
      end
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (w_byte_done) begin
            if (w_byte == CMD_WAKE) begin
              awake_d = 1'b1;
              state_d = IGNORE;
            end else if (w_byte == CMD_READ && awake_q) begin
              addr_cnt_d = 2'd0;
              state_d    = ADDR;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR: begin
          if (rise) addr_sh_d = {addr_sh_q[MEM_AW-3:0], mosi_s};
          if (w_byte_done) begin
            addr_cnt_d = addr_cnt_q + 2'd1;
            if (addr_cnt_q == c_last_addr) begin
              w_addr_done = 1'b1;
              next_addr_d = {addr_sh_q, mosi_s};
              state_d     = DATA;
            end
          end
        end
        DATA: begin
          if (fall) begin
            if (bitcnt_q == 3'd0) begin
              // Byte boundary: move the held byte out, or 0xFF if it never arrived.
              w_load      = 1'b1;
              next_addr_d = next_addr_q + c_addr_one;
              hold_full_d = 1'b0;
              if (hold_full_q) begin
                miso_d  = hold_q[7];
                shout_d = {hold_q[6:0], 1'b1};
              end else begin
                miso_d     = 1'b1;
                shout_d    = 8'hFF;
                underrun_d = 1'b1;
                if (mem_valid_q) discard_d = 1'b1;
              end
            end else begin
              miso_d  = shout_q[7];
              shout_d = {shout_q[6:0], 1'b1};
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end

    // Handshake completion; the byte is kept only if it belongs to the live stream
    // and did not arrive too late for the byte being loaded right now.
    if (mem_valid_q && mem_ready) begin
      mem_valid_d = 1'b0;
      discard_d   = 1'b0;
      if (!discard_q && !cs_s && state_q == DATA && !(w_load && !hold_full_q)) begin
        hold_d      = mem_rdata;
        hold_full_d = 1'b1;
      end
    end

    // Fetch issue: one outstanding request at most; later requests wait their turn.
    w_want = !cs_s && (want_q || w_addr_done || w_load);
    if (w_addr_done)  w_want_addr = {addr_sh_q, mosi_s};
    else if (w_load)  w_want_addr = next_addr_q + c_addr_one;
    if (w_want) begin
      if (!mem_valid_q) begin
        mem_valid_d = 1'b1;
        mem_addr_d  = w_want_addr;
        want_d      = 1'b0;
      end else begin
        want_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      shin_q      <= 7'd0;
      addr_sh_q   <= '0;
      addr_cnt_q  <= 2'd0;
      next_addr_q <= '0;
      want_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      discard_q   <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shout_q     <= 8'hFF;
      miso_q      <= 1'b1;
      awake_q     <= START_AWAKE;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shin_q      <= shin_d;
      addr_sh_q   <= addr_sh_d;
      addr_cnt_q  <= addr_cnt_d;
      next_addr_q <= next_addr_d;
      want_q      <= want_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      discard_q   <= discard_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shout_q     <= shout_d;
      miso_q      <= miso_d;
      awake_q     <= awake_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi_miso  = miso_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign awake     = awake_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire
